alu_exec_pipe: RTL

Two-stage elastic execute unit. It consumes the 3-bit ALUControl code produced by the ALU decoder, together with two operands, and produces the ALU result and a Zero flag. It sits between decode and the cache/writeback path. Valid/ready handshakes on both sides let cache stalls back-pressure execute without losing operations. It also keeps a saturating count of completed operations and a sticky illegal-code flag.

---
 rtl/alu_exec_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu_exec_pipe.sv
// Two-stage elastic ALU execute unit. Stage 1 holds the operands and stage 2 holds
// the result, with valid/ready handshakes on both sides.
module alu_exec_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal_op,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0]       OP_ADD  = 3'b000;
  localparam logic [2:0]       OP_SUB  = 3'b001;
  localparam logic [2:0]       OP_AND  = 3'b010;
  localparam logic [2:0]       OP_OR   = 3'b011;
  localparam logic [2:0]       OP_SLT  = 3'b101;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [2:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;

  logic             s2_load_c;
  logic             accept_c;
  logic             drain_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ill_c;

  // Stage 2 takes a new op when it is empty or its current op is leaving this cycle.
  assign s2_load_c = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load_c;
  assign accept_c  = in_valid && in_ready;
  assign drain_c   = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // ALU datapath on the stage-1 operands; illegal codes produce zero.
  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    case (s1_ctrl)
      OP_ADD:  alu_res_c = s1_a + s1_b;
      OP_SUB:  alu_res_c = s1_a - s1_b;
      OP_AND:  alu_res_c = s1_a & s1_b;
      OP_OR:   alu_res_c = s1_a | s1_b;
      OP_SLT:  alu_res_c = WIDTH'($signed(s1_a) < $signed(s1_b));
      default: alu_ill_c = 1'b1;
    endcase
  end

  // Stage 1: operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_ctrl  <= ALUControl;
      s1_a     <= SrcA;
      s1_b     <= SrcB;
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register; contents hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else if (s2_load_c) begin
      s2_valid  <= 1'b1;
      ALUResult <= alu_res_c;
      Zero      <= (alu_res_c == '0);
    end else if (drain_c) begin
      s2_valid  <= 1'b0;
    end
  end

  // Sticky illegal-code flag and saturating completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
      op_count   <= '0;
    end else begin
      if (s2_load_c && alu_ill_c) begin
        illegal_op <= 1'b1;
      end
      if (drain_c && (op_count != CNT_MAX)) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule
